// File: rtl/l1_trigger_stream_formatter.sv
// l1_trigger_stream_formatter: selects a sample, debug or stretched-trigger stream, packs it into an
// 8x16b AXI4S beat and queues it in a 2-entry skid FIFO that drops new beats when full.
module l1_trigger_stream_formatter #(
  parameter int NCHAN = 8,
  parameter int NBEAMS = 2,
  parameter int STRETCH = 4,
  parameter int OVF_W = 16,
  localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1,
  localparam int SW = STRETCH > 1 ? $clog2(STRETCH) : 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NCHAN*96-1:0] dat_i,
  input  logic [NCHAN*40-1:0] dbg_i,
  input  logic [NBEAMS-1:0]   trig_i,
  input  logic [1:0]          mode_i,
  input  logic [CW-1:0]       chan_sel_i,
  input  logic                cfg_update_i,
  output logic [127:0]        m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [OVF_W-1:0]    ovf_count_o
);
  logic [1:0] mode;
  logic [CW-1:0] chan;
  logic [NBEAMS-1:0][SW-1:0] cnt;
  logic [NBEAMS-1:0] trig_s;
  logic in_range;
  logic [95:0] raw;
  logic [95:0] trig_w;
  logic [39:0] dbg;
  logic [127:0] fmt;
  logic [127:0] pack;
  logic pack_v;
  logic [1:0][127:0] mem;
  logic wp;
  logic rp;
  logic [1:0] fill;
  logic full;
  logic pop;
  logic accept;
  always_comb begin
    trig_s = trig_i;
    for (int b = 0; b < NBEAMS; b++) trig_s[b] = trig_i[b] | (cnt[b] != '0);
  end
  assign in_range = int'(chan) < NCHAN;
  assign raw = in_range ? dat_i[96*int'(chan) +: 96] : '0;
  assign dbg = in_range ? dbg_i[40*int'(chan) +: 40] : '0;
  assign trig_w = 96'(trig_s);
  // Triggers reuse the 12-bit sample lane layout, so beam b sits 4 bits up inside lane b/12.
  always_comb begin
    fmt = '0;
    for (int k = 0; k < 8; k++)
      fmt[16*k +: 16] = mode == 2'd1 ? {11'b0, dbg[5*k +: 5]} :
                        mode == 2'd3 ? 16'h0 :
                        {(mode == 2'd2 ? trig_w[12*k +: 12] : raw[12*k +: 12]), 4'b0};
  end
  assign m_tvalid = fill != 2'd0;
  assign full = fill == 2'd2;
  assign pop = m_tvalid & m_tready;
  assign accept = pack_v & (~full | pop);
  assign m_tdata = mem[rp];
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mode <= '0;
      chan <= '0;
      cnt <= '0;
      pack <= '0;
      pack_v <= 1'b0;
      mem <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fill <= '0;
      ovf_count_o <= '0;
    end else begin
      if (cfg_update_i) begin
        mode <= mode_i;
        chan <= chan_sel_i;
      end
      for (int b = 0; b < NBEAMS; b++)
        cnt[b] <= trig_i[b] ? SW'(STRETCH - 1) : cnt[b] - SW'(cnt[b] != '0);
      pack <= fmt;
      pack_v <= 1'b1;
      if (accept) mem[wp] <= pack;
      wp <= wp ^ accept;
      rp <= rp ^ pop;
      fill <= fill + 2'(accept) - 2'(pop);
      if (pack_v && full && !pop && ovf_count_o != '1) ovf_count_o <= ovf_count_o + OVF_W'(1);
    end
  end
endmodule

// File: tb/tb_l1_trigger_stream_formatter.sv
// tb_l1_trigger_stream_formatter: random and directed stimulus checked against a queue-based
// reference model of the formatter, stretcher and 2-entry drop-new FIFO.
module tb_l1_trigger_stream_formatter;
  localparam int NCHAN = 8;
  localparam int NBEAMS = 2;
  localparam int STRETCH = 4;
  localparam int OVF_W = 16;
  localparam int NCHAN2 = 6;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NCHAN*96-1:0] dat_i;
  logic [NCHAN*40-1:0] dbg_i;
  logic [NBEAMS-1:0] trig_i;
  logic [1:0] mode_i;
  logic [2:0] chan_sel_i;
  logic cfg_update_i;
  logic m_tready;
  logic [127:0] m_tdata;
  logic [127:0] m_tdata2;
  logic m_tvalid;
  logic m_tvalid2;
  logic [OVF_W-1:0] ovf_count_o;
  logic [OVF_W-1:0] ovf2;
  int checks = 0;
  int failures = 0;
  logic [127:0] q[$];
  int ovf_m;
  bit pv_m;
  logic [127:0] pack_m;
  int mode_m;
  int chan_m;
  int cnt_m[NBEAMS];
  int n4;
  int n5;

  always #5 aclk = ~aclk;

  l1_trigger_stream_formatter #(.NCHAN(NCHAN), .NBEAMS(NBEAMS), .STRETCH(STRETCH), .OVF_W(OVF_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .dat_i(dat_i), .dbg_i(dbg_i), .trig_i(trig_i),
    .mode_i(mode_i), .chan_sel_i(chan_sel_i), .cfg_update_i(cfg_update_i),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .ovf_count_o(ovf_count_o));

  // Non-power-of-two channel count so that out-of-range channel selects are reachable.
  l1_trigger_stream_formatter #(.NCHAN(NCHAN2), .NBEAMS(NBEAMS), .STRETCH(STRETCH), .OVF_W(OVF_W)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .dat_i(dat_i[NCHAN2*96-1:0]), .dbg_i(dbg_i[NCHAN2*40-1:0]),
    .trig_i(trig_i), .mode_i(mode_i), .chan_sel_i(chan_sel_i), .cfg_update_i(cfg_update_i),
    .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready), .ovf_count_o(ovf2));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fmt_model();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (mode_m == 0 && chan_m < NCHAN) r[16*k+4 +: 12] = dat_i[96*chan_m+12*k +: 12];
      if (mode_m == 1 && chan_m < NCHAN) r[16*k +: 5] = dbg_i[40*chan_m+5*k +: 5];
    end
    if (mode_m == 2)
      for (int b = 0; b < NBEAMS; b++)
        if (trig_i[b] || cnt_m[b] != 0) r[16*(b/12)+4+(b%12)] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    logic [127:0] f;
    bit pop;
    if (!aresetn) begin
      q.delete();
      ovf_m = 0;
      pv_m = 0;
      pack_m = '0;
      mode_m = 0;
      chan_m = 0;
      foreach (cnt_m[b]) cnt_m[b] = 0;
      return;
    end
    f = fmt_model();
    pop = q.size() > 0 && m_tready;
    if (pop) void'(q.pop_front());
    if (pv_m) begin
      if (q.size() < 2) q.push_back(pack_m);
      else if (ovf_m < 2**OVF_W - 1) ovf_m++;
    end
    pack_m = f;
    pv_m = 1;
    if (cfg_update_i) begin
      mode_m = int'(mode_i);
      chan_m = int'(chan_sel_i);
    end
    foreach (cnt_m[b]) cnt_m[b] = trig_i[b] ? STRETCH - 1 : (cnt_m[b] > 0 ? cnt_m[b] - 1 : 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    @(negedge aclk);
    check("tvalid", 128'(m_tvalid), 128'(q.size() > 0));
    check("ovf", 128'(ovf_count_o), 128'(ovf_m));
    if (q.size() > 0) check("tdata", m_tdata, q[0]);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCHAN*3; i++) dat_i[32*i +: 32] = $urandom;
    for (int i = 0; i < NCHAN*40/32; i++) dbg_i[32*i +: 32] = $urandom;
  endtask

  initial begin
    dat_i = '0;
    dbg_i = '0;
    trig_i = '0;
    mode_i = 2'd0;
    chan_sel_i = 3'd0;
    cfg_update_i = 1'b0;
    m_tready = 1'b0;
    @(negedge aclk);
    repeat (2) tick();
    check("rst_valid", 128'(m_tvalid), 128'(0));
    check("rst_ovf", 128'(ovf_count_o), 128'(0));
    check("rst_tdata", m_tdata, 128'(0));
    // raw samples from channel 3
    aresetn = 1'b1;
    chan_sel_i = 3'd3;
    cfg_update_i = 1'b1;
    m_tready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rand_data();
      for (int k = 0; k < 8; k++) dat_i[96*3+12*k +: 12] = 12'(12'h100 + k);
      tick();
      cfg_update_i = 1'b0;
      if (r >= 2) begin
        check("t1_lane0", 128'(m_tdata[15:0]), 128'(16'h1000));
        check("t1_lane7", 128'(m_tdata[127:112]), 128'(16'h1070));
        check("t1_valid", 128'(m_tvalid), 128'(1));
      end
    end
    // backpressure from the first valid beat
    aresetn = 1'b0;
    m_tready = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (2) begin
      rand_data();
      tick();
    end
    check("t2_first_valid", 128'(m_tvalid), 128'(1));
    repeat (10) begin
      rand_data();
      tick();
    end
    check("t2_ovf9", 128'(ovf_count_o), 128'(9));
    m_tready = 1'b1;
    repeat (20) begin
      rand_data();
      tick();
    end
    // random traffic, config changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      rand_data();
      trig_i = $urandom_range(0, 3) == 0 ? NBEAMS'($urandom) : '0;
      m_tready = $urandom_range(0, 3) != 0;
      cfg_update_i = $urandom_range(0, 15) == 0;
      mode_i = 2'($urandom);
      chan_sel_i = 3'($urandom);
      aresetn = $urandom_range(0, 99) != 0;
      tick();
    end
    aresetn = 1'b1;
    // trigger stretching
    trig_i = '0;
    mode_i = 2'd2;
    cfg_update_i = 1'b1;
    m_tready = 1'b1;
    tick();
    cfg_update_i = 1'b0;
    repeat (8) tick();
    n4 = 0;
    n5 = 0;
    trig_i = 2'b10;
    for (int i = 0; i < 12; i++) begin
      tick();
      trig_i = '0;
      if (m_tvalid) begin
        n4 += int'(m_tdata[4]);
        n5 += int'(m_tdata[5]);
      end
    end
    check("t4_stretch4", 128'(n5), 128'(4));
    check("t4_idle_beam", 128'(n4), 128'(0));
    n5 = 0;
    for (int i = 0; i < 14; i++) begin
      trig_i = (i == 0 || i == 2) ? 2'b10 : 2'b00;
      tick();
      if (m_tvalid) n5 += int'(m_tdata[5]);
    end
    check("t4_retrigger6", 128'(n5), 128'(6));
    // config gating, debug superpack, out-of-range channel
    rand_data();
    dat_i[11:0] = 12'hABC;
    dbg_i[4:0] = 5'h1F;
    mode_i = 2'd0;
    chan_sel_i = 3'd0;
    cfg_update_i = 1'b1;
    tick();
    cfg_update_i = 1'b0;
    mode_i = 2'd1;
    repeat (4) tick();
    check("t5_still_raw", 128'(m_tdata[15:0]), 128'(16'hABC0));
    cfg_update_i = 1'b1;
    tick();
    cfg_update_i = 1'b0;
    repeat (3) tick();
    check("t5_dbg_lane0", 128'(m_tdata[15:0]), 128'(16'h001F));
    for (int m = 0; m < 2; m++) begin
      mode_i = 2'(m);
      chan_sel_i = 3'd6;
      cfg_update_i = 1'b1;
      tick();
      cfg_update_i = 1'b0;
      repeat (3) tick();
      check("t5_oor_valid", 128'(m_tvalid2), 128'(1));
      check("t5_oor_zero", m_tdata2, 128'(0));
    end
    // reset while full with drops pending
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    m_tready = 1'b0;
    repeat (8) begin
      rand_data();
      tick();
    end
    check("t6_ovf5", 128'(ovf_count_o), 128'(5));
    aresetn = 1'b0;
    tick();
    check("t6_rst_valid", 128'(m_tvalid), 128'(0));
    check("t6_rst_ovf", 128'(ovf_count_o), 128'(0));
    aresetn = 1'b1;
    m_tready = 1'b1;
    tick();
    check("t6_no_beat_yet", 128'(m_tvalid), 128'(0));
    tick();
    check("t6_first_beat", 128'(m_tvalid), 128'(1));
    // drop counter saturation
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    m_tready = 1'b0;
    repeat (70000) tick();
    check("t3_sat", 128'(ovf_count_o), 128'(16'hFFFF));
    repeat (5) tick();
    check("t3_sat_hold", 128'(ovf_count_o), 128'(16'hFFFF));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
